// File: rtl/hazard_flow_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_hazard_pkg
// Shared types and constants for the 5-stage MIPS pipeline flow controller.
//   state_t    : flow-controller FSM states (RUN / STALL / FLUSH)
//   DEF_REG_W  : default register-address width
//   CNT_W      : width of the stall/flush down-counter
//   sat_inc16  : saturating 16-bit increment used by the optional perf
//                counters (HAZARD_PERF_CNT_EN)
// -----------------------------------------------------------------------------
package mips_hazard_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam int DEF_REG_W = 5;
   localparam int CNT_W     = 4;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/hazard_flow_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard detector. Flags when the load in EX
// writes a register that the instruction in ID reads. Register 0 is hardwired
// to zero in MIPS, so a load targeting it never creates a dependency.
// Ports:
//   mem_read_ex  in   EX-stage instruction is a load
//   rt_ex        in   destination register of the EX-stage load
//   rs_id        in   ID-stage source register rs
//   rt_id        in   ID-stage source register rt
//   lu_hit       out  load-use hazard present
// -----------------------------------------------------------------------------
module load_use_detect
   import mips_hazard_pkg::*;
#(
   parameter int REG_W = DEF_REG_W
) (
   input  logic             mem_read_ex,
   input  logic [REG_W-1:0] rt_ex,
   input  logic [REG_W-1:0] rs_id,
   input  logic [REG_W-1:0] rt_id,
   output logic             lu_hit
);

   logic w_dst_nonzero;
   logic w_src_match;

   assign w_dst_nonzero = (rt_ex != '0);
   assign w_src_match   = (rt_ex == rs_id) | (rt_ex == rt_id);
   assign lu_hit        = mem_read_ex & w_dst_nonzero & w_src_match;

endmodule

// File: rtl/hazard_flow_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_flow_ctrl
// Pipeline flow controller for the 5-stage MIPS core. Resolves taken branches
// in EX (flush IF/ID and ID/EX, redirect PC) and freezes PC and IF/ID for
// STALL_CYCLES cycles on a load-use hazard. Outputs are combinational from
// the FSM state and the current inputs.
//
// Parameters:
//   REG_W         register-address width
//   STALL_CYCLES  bubbles inserted per load-use hazard (1..15)
//   FLUSH_CYCLES  cycles IF/ID is flushed per taken branch (1..3)
//
// Ports:
//   clk          in   core clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   branch_ex    in   EX instruction is a conditional branch
//   zero_ex      in   ALU zero flag of the EX instruction
//   mem_read_ex  in   EX instruction is a load
//   rt_ex        in   destination register of the EX load
//   rs_id        in   ID source register rs
//   rt_id        in   ID source register rt
//   pc_src_sel   out  1 = PC takes the branch target
//   pc_write     out  PC load enable
//   ifid_write   out  IF/ID load enable
//   ifid_flush   out  IF/ID cleared to NOP
//   idex_flush   out  ID/EX cleared to bubble
//   stall        out  load-use stall active
//   taken_cnt    out  [HAZARD_PERF_CNT_EN] saturating count of taken branches
//   stall_cnt    out  [HAZARD_PERF_CNT_EN] saturating count of stall cycles
//
// Optional feature macro: HAZARD_PERF_CNT_EN
// -----------------------------------------------------------------------------
module hazard_flow_ctrl
   import mips_hazard_pkg::*;
#(
   parameter int REG_W        = DEF_REG_W,
   parameter int STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             branch_ex,
   input  logic             zero_ex,
   input  logic             mem_read_ex,
   input  logic [REG_W-1:0] rt_ex,
   input  logic [REG_W-1:0] rs_id,
   input  logic [REG_W-1:0] rt_id,
   output logic             pc_src_sel,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             stall
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [15:0]      taken_cnt,
   output logic [15:0]      stall_cnt
`endif
);

   // Counter preload values: the first hazard cycle is spent in RUN, so the
   // extra states only cover the remaining cycles.
   localparam logic [CNT_W-1:0] LP_STALL_LOAD =
      (STALL_CYCLES > 1) ? CNT_W'(STALL_CYCLES - 2) : '0;
   localparam logic [CNT_W-1:0] LP_FLUSH_LOAD =
      (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : '0;
   localparam bit LP_USE_STALL_ST = (STALL_CYCLES > 1);
   localparam bit LP_USE_FLUSH_ST = (FLUSH_CYCLES > 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_next_cnt;
   // Low from reset until the first rising edge after rst_n releases; inputs
   // are ignored while it is low, which also forces reset-valued outputs.
   logic             r_armed;
   logic             w_taken;
   logic             w_lu_hit;
   logic             w_taken_run;

   assign w_taken = branch_ex & zero_ex;

   load_use_detect #(
      .REG_W (REG_W)
   ) u_load_use_detect (
      .mem_read_ex (mem_read_ex),
      .rt_ex       (rt_ex),
      .rs_id       (rs_id),
      .rt_id       (rt_id),
      .lu_hit      (w_lu_hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_cnt   <= '0;
         r_armed <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         r_armed <= 1'b1;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_taken_run  = 1'b0;
      pc_src_sel   = 1'b0;
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      stall        = 1'b0;

      if (r_armed) begin
         case (r_state)
            RUN: begin
               // A branch and a load cannot both be in EX; if the encoding
               // claims both, the branch wins and the stall is dropped.
               if (w_taken) begin
                  w_taken_run = 1'b1;
                  pc_src_sel  = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  if (LP_USE_FLUSH_ST) begin
                     w_next_state = FLUSH;
                     w_next_cnt   = LP_FLUSH_LOAD;
                  end
               end else if (w_lu_hit) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_flush = 1'b1;
                  stall      = 1'b1;
                  if (LP_USE_STALL_ST) begin
                     w_next_state = STALL;
                     w_next_cnt   = LP_STALL_LOAD;
                  end
               end
            end

            // EX holds a bubble here, so branch/load inputs are meaningless.
            STALL: begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_flush = 1'b1;
               stall      = 1'b1;
               if (r_cnt == '0) begin
                  w_next_state = RUN;
               end else begin
                  w_next_cnt = r_cnt - CNT_W'(1);
               end
            end

            FLUSH: begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               if (r_cnt == '0) begin
                  w_next_state = RUN;
               end else begin
                  w_next_cnt = r_cnt - CNT_W'(1);
               end
            end

            default: begin
               w_next_state = RUN;
               w_next_cnt   = '0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] r_taken_cnt;
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_taken_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_taken_run) begin
            r_taken_cnt <= sat_inc16(r_taken_cnt);
         end
         if (stall) begin
            r_stall_cnt <= sat_inc16(r_stall_cnt);
         end
      end
   end

   assign taken_cnt = r_taken_cnt;
   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_flow_ctrl
// Self-checking bench for hazard_flow_ctrl (STALL_CYCLES=2, FLUSH_CYCLES=2).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// The reference model tracks only "cycles of penalty left" and its kind.
// Observed vector: {pc_src_sel, pc_write, ifid_write, ifid_flush, idex_flush,
// stall}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_flow_ctrl;

   localparam int REG_W = 5;
   localparam int SC    = 2;
   localparam int FC    = 2;
   localparam logic [5:0] EXP_IDLE = 6'b011000;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             branch_ex, zero_ex, mem_read_ex;
   logic [REG_W-1:0] rt_ex, rs_id, rt_id;
   logic             pc_src_sel, pc_write, ifid_write, ifid_flush, idex_flush, stall;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0]      taken_cnt, stall_cnt;
`endif
   logic [5:0]       obs;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m_left     = 0;
   bit m_in_flush = 1'b0;

   always #5 clk = ~clk;

   assign obs = {pc_src_sel, pc_write, ifid_write, ifid_flush, idex_flush, stall};

   hazard_flow_ctrl #(
      .REG_W        (REG_W),
      .STALL_CYCLES (SC),
      .FLUSH_CYCLES (FC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .branch_ex   (branch_ex),
      .zero_ex     (zero_ex),
      .mem_read_ex (mem_read_ex),
      .rt_ex       (rt_ex),
      .rs_id       (rs_id),
      .rt_id       (rt_id),
      .pc_src_sel  (pc_src_sel),
      .pc_write    (pc_write),
      .ifid_write  (ifid_write),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .stall       (stall)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .taken_cnt   (taken_cnt),
      .stall_cnt   (stall_cnt)
`endif
   );

   // Expected outputs for the current cycle, then advance past the clock edge.
   task automatic model_step(output logic [5:0] exp);
      bit tk, lu;
      tk = branch_ex && zero_ex;
      lu = mem_read_ex && (rt_ex != 0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
      if (m_left > 0) begin
         exp    = m_in_flush ? 6'b011110 : 6'b000011;
         m_left = m_left - 1;
      end else if (tk) begin
         exp        = 6'b111110;
         m_left     = FC - 1;
         m_in_flush = 1'b1;
      end else if (lu) begin
         exp        = 6'b000011;
         m_left     = SC - 1;
         m_in_flush = 1'b0;
      end else begin
         exp = EXP_IDLE;
      end
   endtask

   task automatic drive(input logic b, input logic z, input logic mr,
                        input logic [REG_W-1:0] rte, input logic [REG_W-1:0] rsi,
                        input logic [REG_W-1:0] rti, output logic [5:0] exp);
      @(negedge clk);
      branch_ex   = b;
      zero_ex     = z;
      mem_read_ex = mr;
      rt_ex       = rte;
      rs_id       = rsi;
      rt_id       = rti;
      #1;
      model_step(exp);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      branch_ex = 0; zero_ex = 0; mem_read_ex = 0; rt_ex = 0; rs_id = 0; rt_id = 0;
      @(negedge clk);
      rst_n      = 1'b1;
      m_left     = 0;
      m_in_flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      branch_ex = 1; zero_ex = 1; mem_read_ex = 1; rt_ex = 5'd3; rs_id = 5'd3; rt_id = 5'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if (obs !== EXP_IDLE) begin
            n_fail++;
            $display("FAIL reset_hold_%0d: got %b expected %b", i, obs, EXP_IDLE);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (obs !== EXP_IDLE) begin
         n_fail++;
         $display("FAIL reset_release_pre_edge: got %b expected %b", obs, EXP_IDLE);
      end
      m_left = 0;
      m_in_flush = 1'b0;
   endtask

   task automatic test_taken_branch();
      logic [5:0] exp;
      logic [5:0] want [3] = '{6'b111110, 6'b011110, EXP_IDLE};
      for (int i = 0; i < 3; i++) begin
         if (i == 0) drive(1, 1, 0, 0, 0, 0, exp);
         else        drive(0, 0, 0, 0, 0, 0, exp);
         n_checks++;
         if (obs !== exp || obs !== want[i]) begin
            n_fail++;
            $display("FAIL taken_c%0d: got %b expected %b", i, obs, want[i]);
         end
      end
   endtask

   task automatic test_untaken_branch();
      logic [5:0] exp;
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 5'd4, 5'd4, 5'd1, exp);
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL untaken_c%0d: got %b expected %b", i, obs, exp);
         end
      end
   endtask

   task automatic test_load_use();
      logic [5:0] exp;
      logic [5:0] want [3] = '{6'b000011, 6'b000011, EXP_IDLE};
      for (int i = 0; i < 3; i++) begin
         if (i < 2) drive(0, 0, 1, 5'd8, 5'd8, 5'd2, exp);
         else       drive(0, 0, 0, 5'd8, 5'd8, 5'd2, exp);
         n_checks++;
         if (obs !== exp || obs !== want[i]) begin
            n_fail++;
            $display("FAIL load_use_c%0d: got %b expected %b", i, obs, want[i]);
         end
      end
   endtask

   task automatic test_no_stall();
      logic [5:0] exp;
      drive(0, 0, 1, 5'd0, 5'd0, 5'd0, exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL no_stall_r0: got %b expected %b", obs, exp);
      end
      drive(0, 0, 1, 5'd9, 5'd8, 5'd10, exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL no_stall_mismatch_regs: got %b expected %b", obs, exp);
      end
      drive(0, 0, 1, 5'd10, 5'd8, 5'd10, exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL stall_via_rt_id: got %b expected %b", obs, exp);
      end
      drive(0, 0, 0, 5'd0, 5'd0, 5'd0, exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL stall_via_rt_id_c1: got %b expected %b", obs, exp);
      end
   endtask

   task automatic test_simultaneous();
      logic [5:0] exp;
      drive(1, 1, 1, 5'd7, 5'd7, 5'd7, exp);
      n_checks++;
      if (obs !== exp || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL taken_beats_stall: got %b expected %b", obs, exp);
      end
      drive(0, 0, 0, 0, 0, 0, exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL taken_beats_stall_c1: got %b expected %b", obs, exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] exp;
      // hazard held across stall exit, then branch straight after, then load
      // hazard straight after the flush
      for (int i = 0; i < 9; i++) begin
         case (i)
            0, 1, 2, 3: drive(0, 0, 1, 5'd5, 5'd1, 5'd5, exp);
            4, 5:       drive(1, 1, 0, 5'd0, 5'd0, 5'd0, exp);
            6, 7:       drive(0, 0, 1, 5'd6, 5'd6, 5'd0, exp);
            default:    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, exp);
         endcase
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL back_to_back_c%0d: got %b expected %b", i, obs, exp);
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] exp;
      logic b, z, mr;
      logic [REG_W-1:0] rte, rsi, rti;
      for (int i = 0; i < 400; i++) begin
         b   = ($urandom_range(0, 3) == 0);
         z   = $urandom_range(0, 1);
         mr  = $urandom_range(0, 1);
         rte = REG_W'($urandom_range(0, 3));
         rsi = REG_W'($urandom_range(0, 3));
         rti = REG_W'($urandom_range(0, 3));
         drive(b, z, mr, rte, rsi, rti, exp);
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL random_c%0d: got %b expected %b", i, obs, exp);
         end
      end
      drive(0, 0, 0, 0, 0, 0, exp);
      drive(0, 0, 0, 0, 0, 0, exp);
   endtask

   task automatic test_mid_reset();
      logic [5:0] exp;
      drive(0, 0, 1, 5'd12, 5'd12, 5'd0, exp);
      drive(1, 1, 0, 5'd0, 5'd0, 5'd0, exp);   // second stall cycle
      n_checks++;
      if (obs !== 6'b000011) begin
         n_fail++;
         $display("FAIL mid_reset_pre: got %b expected %b", obs, 6'b000011);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== EXP_IDLE) begin
         n_fail++;
         $display("FAIL mid_reset_async: got %b expected %b", obs, EXP_IDLE);
      end
      @(negedge clk);
      rst_n = 1'b1;
      branch_ex = 0; zero_ex = 0;
      m_left = 0;
      m_in_flush = 1'b0;
      drive(0, 0, 0, 0, 0, 0, exp);
      n_checks++;
      if (obs !== EXP_IDLE || obs !== exp) begin
         n_fail++;
         $display("FAIL mid_reset_run: got %b expected %b", obs, EXP_IDLE);
      end
   endtask

   task automatic test_perf_cnt();
`ifdef HAZARD_PERF_CNT_EN
      logic [5:0] exp;
      apply_reset();
      @(negedge clk);
      n_checks++;
      if (taken_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL perf_reset: got %0d/%0d expected 0/0", taken_cnt, stall_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 0, 0, 0, exp);
         drive(0, 0, 0, 0, 0, 0, exp);
      end
      drive(0, 0, 1, 5'd8, 5'd8, 5'd0, exp);
      drive(0, 0, 0, 0, 0, 0, exp);
      drive(0, 0, 0, 0, 0, 0, exp);
      n_checks++;
      if (taken_cnt !== 16'd3 || stall_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL perf_counts: got %0d/%0d expected 3/2", taken_cnt, stall_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_taken_branch();
      test_untaken_branch();
      test_load_use();
      test_no_stall();
      test_simultaneous();
      test_back_to_back();
      test_random();
      test_mid_reset();
      test_perf_cnt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_flow_ctrl.md
Name: hazard_flow_ctrl

Overview:
- Pipeline flow controller for the 5-stage MIPS core.
- Resolves taken branches in EX from the branch and zero flags, and drives PC-source select plus IF/ID and ID/EX flushes.
- Detects load-use hazards and freezes PC and IF/ID for a programmable number of cycles.
- Sits beside the hazard/forwarding logic; its outputs gate the PC register, the IF/ID register and the ID/EX register.

Parameters:
- REG_W, 5, register-address width.
- STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15).
- FLUSH_CYCLES, 1, cycles IF/ID is flushed per taken branch (1..3).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- branch_ex  input  1  EX-stage instruction is a conditional branch.
- zero_ex  input  1  ALU zero flag of the EX-stage instruction.
- mem_read_ex  input  1  EX-stage instruction is a load.
- rt_ex  input  REG_W  destination register of the EX-stage load.
- rs_id  input  REG_W  ID-stage source register rs.
- rt_id  input  REG_W  ID-stage source register rt.
- pc_src_sel  output  1  1 = PC takes the branch target.
- pc_write  output  1  PC load enable.
- ifid_write  output  1  IF/ID load enable.
- ifid_flush  output  1  IF/ID cleared to NOP.
- idex_flush  output  1  ID/EX cleared to bubble.
- stall  output  1  status: load-use stall active.

Behaviour:
- Internal signals:
  - taken = branch_ex & zero_ex.
  - lu_hit = mem_read_ex & (rt_ex != 0) & ((rt_ex == rs_id) | (rt_ex == rt_id)).
- FSM states: RUN, STALL, FLUSH. The state register and a 4-bit down-counter cnt are reset asynchronously.
- Outputs are combinational from state and inputs, with no extra latency.
- Reset (rst_n=0):
  - state = RUN, cnt = 0.
  - pc_src_sel=0, pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0, stall=0.
  - All inputs are ignored until the first rising edge after rst_n rises.
- RUN, taken=1:
  - Same cycle: pc_src_sel=1, ifid_flush=1, idex_flush=1, pc_write=1.
  - If FLUSH_CYCLES>1: next state is FLUSH with cnt=FLUSH_CYCLES-2. Otherwise stay in RUN.
- RUN, lu_hit=1 and taken=0:
  - Same cycle: pc_write=0, ifid_write=0, idex_flush=1, stall=1.
  - If STALL_CYCLES>1: next state is STALL with cnt=STALL_CYCLES-2. Otherwise stay in RUN.
- RUN, neither condition: default outputs (pc_write=1, ifid_write=1, all others 0).
- STALL:
  - pc_write=0, ifid_write=0, idex_flush=1, stall=1.
  - Branch and load inputs are ignored, because EX holds a bubble.
  - If cnt==0, go to RUN; else decrement cnt.
- FLUSH:
  - ifid_flush=1, pc_write=1, pc_src_sel=0, idex_flush=1.
  - Inputs are ignored.
  - If cnt==0, go to RUN; else decrement cnt.
- Simultaneous taken and lu_hit (illegal encoding for one EX instruction): taken wins, and the stall is dropped.
- rt_ex==0 never causes a stall.
- Reset asserted mid-STALL or mid-FLUSH: the FSM returns to RUN immediately (asynchronously), and outputs take their reset values the same instant.
- Back-to-back hazard on return to RUN: the hazard is evaluated normally in the first RUN cycle, with no dead cycle in between.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds output ports taken_cnt[15:0] and stall_cnt[15:0].
  - taken_cnt increments on every RUN cycle with taken=1.
  - stall_cnt increments on every cycle with stall=1.
  - Both counters saturate at 16'hFFFF and reset to 0 on rst_n=0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mips_hazard_pkg holds:
  - the state enum (RUN=2'd0, STALL=2'd1, FLUSH=2'd2);
  - the REG_W default;
  - the counter width constant CNT_W=4.
- One sub-module, load_use_detect: purely combinational, computes lu_hit from mem_read_ex, rt_ex, rs_id and rt_id.
- The FSM, counter and optional perf counters stay in hazard_flow_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with branch_ex=1, zero_ex=1 -> pc_src_sel=0, pc_write=1, all flushes 0.
- Taken branch: branch_ex=1, zero_ex=1, FLUSH_CYCLES=2 -> cycle 0: pc_src_sel=1, ifid_flush=1, idex_flush=1; cycle 1: ifid_flush=1, pc_src_sel=0; cycle 2: RUN defaults.
- Untaken branch: branch_ex=1, zero_ex=0 -> no flush, pc_write=1.
- Load-use: mem_read_ex=1, rt_ex=8, rs_id=8, STALL_CYCLES=2 -> pc_write=0, ifid_write=0, stall=1 for exactly 2 cycles, then RUN.
- No stall cases:
  - mem_read_ex=1, rt_ex=0, rs_id=0 -> stall=0.
  - rt_ex=9, rs_id=8, rt_id=10 -> stall=0.
- Mid-operation reset and perf counters: drop rst_n during the second STALL cycle -> state RUN immediately. With HAZARD_PERF_CNT_EN, 3 taken branches and 1 two-cycle stall -> taken_cnt=3, stall_cnt=2.
